// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation/bring-up run controller: FSM state encoding
// and the reset-channel release schedule.
package sim_ctrl_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_RESET_HOLD = 3'd0,
    ST_RUN        = 3'd1,
    ST_DRAIN      = 3'd2,
    ST_DONE       = 3'd3,
    ST_TIMEOUT    = 3'd4
  } run_state_e;

  // rst_cnt value on whose edge channel k leaves reset
  function automatic int unsigned rst_release_cnt(input int unsigned base,
                                                  input int unsigned stagger,
                                                  input int unsigned k);
    return base - 1 + k * stagger;
  endfunction

endpackage

// File: rtl/sim_sat_cnt.sv
// Up-counter with enable, synchronous clear, async active-low reset; holds at
// all-ones instead of wrapping.
module sim_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         sat
);

  assign sat = &q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          q <= '0;
    else if (clr)        q <= '0;
    else if (en && !sat) q <= q + W'(1);
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: staggered DUT reset release, RUN cycle counting, halt drain
// and timeout. Define SIM_RUN_CTRL_TRACE_EN for simulation progress messages.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned     RST_CYCLES     = 25,
  parameter int unsigned     NUM_RST        = 2,
  parameter int unsigned     RST_STAGGER    = 4,
  parameter int unsigned     CNT_W          = 32,
  parameter longint unsigned TIMEOUT_CYCLES = 150000000,
  parameter int unsigned     DRAIN_CYCLES   = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic               halt_in,
  input  logic               stall_in,
  output logic [NUM_RST-1:0] dut_rst_out,
  output logic               running_out,
  output logic               done_out,
  output logic               timeout_out,
  output logic [CNT_W-1:0]   cycle_cnt_out,
  output logic [ST_W-1:0]    state_out
);

  localparam int unsigned RST_LAST = rst_release_cnt(RST_CYCLES, RST_STAGGER, NUM_RST - 1);
  localparam int unsigned RW       = $clog2(RST_LAST + 2);
  localparam int unsigned DW       = $clog2(DRAIN_CYCLES + 1);

  run_state_e         state_q, state_nxt;
  logic [NUM_RST-1:0] dut_rst_nxt;
  logic               clr, cyc_en, rst_en, drn_en;
  logic [RW-1:0]      rst_cnt;
  logic [DW-1:0]      drn_cnt;
  logic [CNT_W-1:0]   cyc_cnt;
  logic               cyc_sat, rst_sat, drn_sat;
  logic               unused_sat;

  assign unused_sat = &{1'b0, cyc_sat, rst_sat, drn_sat};

  always_comb begin
    state_nxt   = state_q;
    dut_rst_nxt = dut_rst_out;
    clr         = 1'b0;
    cyc_en      = 1'b0;
    rst_en      = 1'b0;
    drn_en      = 1'b0;
    if (start_in) begin
      state_nxt   = ST_RESET_HOLD;
      dut_rst_nxt = '1;
      clr         = 1'b1;
    end else begin
      case (state_q)
        ST_RESET_HOLD: begin
          rst_en = 1'b1;
          for (int unsigned k = 0; k < NUM_RST; k++) begin
            if (rst_cnt == RW'(rst_release_cnt(RST_CYCLES, RST_STAGGER, k)))
              dut_rst_nxt[k] = 1'b0;
          end
          if (rst_cnt == RW'(RST_LAST)) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // halt wins over a timeout landing on the same edge
          if (halt_in) begin
            state_nxt = ST_DRAIN;
          end else if (!stall_in) begin
            cyc_en = 1'b1;
            if (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) state_nxt = ST_TIMEOUT;
          end
        end
        ST_DRAIN: begin
          drn_en = 1'b1;
          if (drn_cnt == DW'(DRAIN_CYCLES - 1)) state_nxt = ST_DONE;
        end
        ST_DONE, ST_TIMEOUT: ;
        default: begin
          state_nxt   = ST_RESET_HOLD;
          dut_rst_nxt = '1;
          clr         = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_RESET_HOLD;
      dut_rst_out <= '1;
      running_out <= 1'b0;
      done_out    <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      dut_rst_out <= dut_rst_nxt;
      running_out <= (state_nxt == ST_RUN);
      done_out    <= (state_nxt == ST_DONE) || (state_nxt == ST_TIMEOUT);
      timeout_out <= (state_nxt == ST_TIMEOUT);
    end
  end

  assign state_out     = state_q;
  assign cycle_cnt_out = cyc_cnt;

  sim_sat_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk(clk_in), .rst_n(rst_n_in), .clr(clr), .en(cyc_en), .q(cyc_cnt), .sat(cyc_sat)
  );

  sim_sat_cnt #(.W(RW)) u_rst_cnt (
    .clk(clk_in), .rst_n(rst_n_in), .clr(clr), .en(rst_en), .q(rst_cnt), .sat(rst_sat)
  );

  sim_sat_cnt #(.W(DW)) u_drn_cnt (
    .clk(clk_in), .rst_n(rst_n_in), .clr(clr), .en(drn_en), .q(drn_cnt), .sat(drn_sat)
  );

`ifdef SIM_RUN_CTRL_TRACE_EN
  logic fin_pending;

  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      fin_pending <= 1'b0;
    end else begin
      if (fin_pending) $finish;
      if (state_q != ST_DONE && state_nxt == ST_DONE) begin
        $display("PASS cycles=%0d", cyc_cnt);
        fin_pending <= 1'b1;
      end
      if (state_q != ST_TIMEOUT && state_nxt == ST_TIMEOUT) begin
        $display("TIMEOUT cycles=%0d", cyc_cnt + CNT_W'(1));
        fin_pending <= 1'b1;
      end
      for (int unsigned k = 0; k < NUM_RST; k++) begin
        if (dut_rst_out[k] && !dut_rst_nxt[k])
          $display("rst[%0d] released @%0t", k, $time);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: expected output snapshots are queued as
// each edge's stimulus is applied and compared one time unit after the edge.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  dut_rst;
  logic        running, done, timeout;
  logic [31:0] cnt;
  logic [2:0]  st;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "reset";

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  rst;
    logic        run;
    logic        done;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sim_run_ctrl #(
    .RST_CYCLES(4),
    .NUM_RST(3),
    .RST_STAGGER(2),
    .CNT_W(32),
    .TIMEOUT_CYCLES(20),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .start_in(start),
    .halt_in(halt),
    .stall_in(stall),
    .dut_rst_out(dut_rst),
    .running_out(running),
    .done_out(done),
    .timeout_out(timeout),
    .cycle_cnt_out(cnt),
    .state_out(st)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int r, input int run, input int dn,
                              input int to, input int c);
    exp_t e;
    e.st   = 3'(s);
    e.rst  = 3'(r);
    e.run  = 1'(run);
    e.done = 1'(dn);
    e.to   = 1'(to);
    e.cnt  = 32'(c);
    return e;
  endfunction

  task automatic observe();
    exp_t e;
    e = sb.pop_front();
    check({phase, ".state"},   64'(st),      64'(e.st));
    check({phase, ".dut_rst"}, 64'(dut_rst), 64'(e.rst));
    check({phase, ".running"}, 64'(running), 64'(e.run));
    check({phase, ".done"},    64'(done),    64'(e.done));
    check({phase, ".timeout"}, 64'(timeout), 64'(e.to));
    check({phase, ".cycles"},  64'(cnt),     64'(e.cnt));
  endtask

  task automatic tick(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic now_check(input exp_t e);
    sb.push_back(e);
    observe();
  endtask

  // 111 -> 110 after edge 4, -> 100 after edge 6, -> 000 and RUN after edge 8
  task automatic release_seq();
    for (int e = 1; e <= 8; e++) begin
      int r;
      r = (e >= 8) ? 0 : (e >= 6) ? 4 : (e >= 4) ? 6 : 7;
      tick(mk((e == 8) ? 1 : 0, r, (e == 8) ? 1 : 0, 0, 0, 0));
    end
  endtask

  task automatic run_free(input int n, input int base);
    for (int i = 1; i <= n; i++) tick(mk(1, 0, 1, 0, 0, base + i));
  endtask

  task automatic restart();
    start = 1'b1;
    tick(mk(0, 7, 0, 0, 0, 0));
    start = 1'b0;
    release_seq();
  endtask

  initial begin
    #12;
    now_check(mk(0, 7, 0, 0, 0, 0));
    rst_n = 1'b1;
    phase = "rel1";
    release_seq();

    phase = "halt";
    run_free(5, 0);
    stall = 1'b1;
    repeat (3) tick(mk(1, 0, 1, 0, 0, 5));
    stall = 1'b0;
    halt  = 1'b1;
    tick(mk(2, 0, 0, 0, 0, 5));
    halt = 1'b0;
    tick(mk(2, 0, 0, 0, 0, 5));
    tick(mk(2, 0, 0, 0, 0, 5));
    tick(mk(3, 0, 0, 1, 0, 5));
    halt  = 1'b1;
    stall = 1'b1;
    repeat (2) tick(mk(3, 0, 0, 1, 0, 5));
    halt  = 1'b0;
    stall = 1'b0;

    phase = "restart";
    restart();

    phase = "timeout";
    run_free(19, 0);
    tick(mk(4, 0, 0, 1, 1, 20));
    for (int i = 0; i < 50; i++) begin
      halt  = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      tick(mk(4, 0, 0, 1, 1, 20));
    end
    halt  = 1'b0;
    stall = 1'b0;

    phase = "collide";
    restart();
    run_free(19, 0);
    halt = 1'b1;
    tick(mk(2, 0, 0, 0, 0, 19));
    halt = 1'b0;
    tick(mk(2, 0, 0, 0, 0, 19));
    tick(mk(2, 0, 0, 0, 0, 19));
    tick(mk(3, 0, 0, 1, 0, 19));

    phase = "start_halt";
    restart();
    run_free(2, 0);
    start = 1'b1;
    halt  = 1'b1;
    tick(mk(0, 7, 0, 0, 0, 0));
    halt = 1'b0;
    repeat (3) tick(mk(0, 7, 0, 0, 0, 0));
    start = 1'b0;
    release_seq();

    phase = "async";
    run_free(3, 0);
    halt = 1'b1;
    tick(mk(2, 0, 0, 0, 0, 3));
    halt = 1'b0;
    tick(mk(2, 0, 0, 0, 0, 3));
    #3 rst_n = 1'b0;
    #1 now_check(mk(0, 7, 0, 0, 0, 0));
    #1 rst_n = 1'b1;
    release_seq();
    run_free(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still-running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Parametrised run controller for simulation and FPGA bring-up that sits between the board/testbench clock-reset source and the CPU top.
- Generates NUM_RST staggered, active-high reset channels for DUT sub-domains.
- Counts executed (non-stalled) cycles, detects program halt, drains for UART flush, and flags timeout.
- Replaces the fixed hand-written clock/reset/timeout sequencing with a reusable, synthesizable block.

Parameters:
- RST_CYCLES, 25: edges channel 0 is held in reset after async reset release; ≥1.
- NUM_RST, 2: number of DUT reset channels; ≥1.
- RST_STAGGER, 4: extra edges of hold per successive channel; ≥0.
- CNT_W, 32: cycle counter width.
- TIMEOUT_CYCLES, 150000000: RUN cycle budget; 1 ≤ value < 2^CNT_W.
- DRAIN_CYCLES, 16: edges spent in DRAIN after halt; ≥1.

Ports:
- clk_in, input, 1: single clock.
- rst_n_in, input, 1: reset, asynchronous, active-low.
- start_in, input, 1: synchronous re-arm pulse (soft restart).
- halt_in, input, 1: DUT program-end indication.
- stall_in, input, 1: DUT not ready; freezes cycle counting.
- dut_rst_out, output, NUM_RST: per-channel reset, active-high.
- running_out, output, 1: high in RUN.
- done_out, output, 1: sticky, high in DONE or TIMEOUT.
- timeout_out, output, 1: sticky, high in TIMEOUT only.
- cycle_cnt_out, output, CNT_W: counted RUN cycles.
- state_out, output, 3: encoded FSM state.

Behaviour:
- rst_n_in low: immediately, regardless of state:
  - state = RESET_HOLD (0); dut_rst_out all ones.
  - running_out, done_out, timeout_out = 0; cycle_cnt_out = 0; internal rst_cnt and drain_cnt = 0.
- State encoding: RESET_HOLD=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4. Values 5–7 are illegal and recover to RESET_HOLD on the next edge.
- RESET_HOLD:
  - rst_cnt increments every edge.
  - dut_rst_out[k] is cleared on the edge where rst_cnt == RST_CYCLES-1+k*RST_STAGGER, so channel k is released after RST_CYCLES+k*RST_STAGGER edges. A released channel stays low.
  - The state moves to RUN on the same edge that releases channel NUM_RST-1.
- RUN:
  - running_out = 1.
  - Per edge, evaluated in priority order:
    1. halt_in=1 → DRAIN; cycle_cnt is not incremented on this edge.
    2. Otherwise, stall_in=0 and cycle_cnt == TIMEOUT_CYCLES-1 → TIMEOUT, with cycle_cnt = TIMEOUT_CYCLES.
    3. Otherwise, stall_in=0 → cycle_cnt+1.
    4. Otherwise (stall_in=1) → hold.
  - halt_in takes priority over timeout on the same edge.
  - The counter never wraps; it saturates at 2^CNT_W-1 as a defensive measure.
- DRAIN:
  - cycle_cnt is frozen; drain_cnt increments each edge.
  - After DRAIN_CYCLES edges in DRAIN → DONE.
  - halt_in and stall_in are ignored.
- DONE: done_out = 1; all outputs hold until start_in or reset.
- TIMEOUT: done_out = 1 and timeout_out = 1; all outputs hold until start_in or reset.
- start_in=1 on any edge, in any state:
  - Next state is RESET_HOLD; dut_rst_out is set to all ones on that edge.
  - All counters and status flags clear, exactly like async reset but synchronous.
  - start_in overrides halt_in, stall_in and timeout on the same edge.
  - Held high, it keeps the block in RESET_HOLD with rst_cnt = 0.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro: SIM_RUN_CTRL_TRACE_EN.
- Defined:
  - On entry to DONE, $display prints "PASS cycles=<cycle_cnt>".
  - On entry to TIMEOUT, $display prints "TIMEOUT cycles=<cycle_cnt>".
  - In either case, $finish is called one edge later.
  - On every reset-channel release, $display prints "rst[k] released @<time>".
- Undefined: no system tasks; the block is purely synthesizable with identical port behaviour.

Decomposition:
- Shared package sim_ctrl_pkg holds:
  - the state typedef and the 3-bit encodings listed above;
  - ST_W = 3 constant.
- One natural sub-module, sim_sat_cnt: a parametrised-width counter with enable, synchronous clear, async active-low reset and a saturate flag. It is instantiated for cycle_cnt, rst_cnt and drain_cnt.

Test Plan:
- Bench parameters: RST_CYCLES=4, NUM_RST=3, RST_STAGGER=2, TIMEOUT_CYCLES=20, DRAIN_CYCLES=3.
- Reset release: deassert rst_n_in → dut_rst_out goes 111→110 after edge 4, →100 after edge 6, →000 after edge 8; state_out=1 and running_out=1 after edge 8.
- Halt with stalls: in RUN, 5 free edges, then 3 stalled edges, then halt_in pulse → cycle_cnt_out=5; state 2 for 3 edges; then done_out=1, timeout_out=0, state_out=3.
- Timeout: never assert halt_in, stall_in=0 → on the 20th RUN edge state_out=4, timeout_out=1, done_out=1, cycle_cnt_out=20; outputs stable for 50 further edges.
- Halt vs. timeout collision: halt_in=1 on the edge where cycle_cnt=19 → DRAIN, then DONE, timeout_out=0, cycle_cnt_out=19.
- Restart and async reset:
  - start_in pulse in DONE → next edge dut_rst_out=111, flags clear, release sequence repeats exactly.
  - start_in asserted in the same cycle as halt_in → RESET_HOLD.
  - rst_n_in dropped mid-DRAIN → outputs return to reset values immediately, without waiting for a clock edge.
- Trace macro: build with SIM_RUN_CTRL_TRACE_EN → bench sees "PASS cycles=5" and simulation ends one edge after DONE; build without it → no messages and the same waveforms.
